// File: rtl/instr_mem_ctrl_if.sv
// Fetch-side bus of the instruction memory controller: a level-held READ
// request stalled by BUSYWAIT, with a registered READDATA word and an ERROR pulse.
interface instr_mem_ctrl_if #(
  parameter int ADDR_W     = 10,
  parameter int WORD_BYTES = 4
) ();
  logic                    read;
  logic [ADDR_W-1:0]       address;
  logic [8*WORD_BYTES-1:0] readdata;
  logic                    busywait;
  logic                    error;

  modport master (
    output read, address,
    input  readdata, busywait, error
  );

  modport slave (
    input  read, address,
    output readdata, busywait, error
  );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Byte-addressed instruction memory with a fixed-latency word fetch FSM, a
// byte-wide preload port and a saturating completed-fetch counter.
module instr_mem_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int WORD_BYTES = 4,
  parameter int LATENCY    = 3,
  parameter int BIG_ENDIAN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_mem_ctrl_if.slave   bus,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [7:0]        i_load_data,
  output logic [15:0]       o_read_count
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam int DATA_W = 8 * WORD_BYTES;

  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_readdata;
  logic                r_error;
  logic [15:0]         r_read_count;
  logic [7:0]          r_mem [DEPTH];

  logic                w_aligned;
  logic [DATA_W-1:0]   w_word;

  assign w_aligned = (bus.address & ALIGN_MASK) == '0;

  // NOTE: storage has no reset branch; contents must survive rst_n and a
  // resettable RAM could not map onto a block memory.
  always_ff @(posedge clk) begin
    if (i_load_en) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  // Aligned words never cross the top of storage, so r_addr + k cannot wrap.
  // NOTE: w_word gets a default before the loop so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (BIG_ENDIAN != 0) begin
        w_word[8*(WORD_BYTES-1-k) +: 8] = r_mem[r_addr + ADDR_W'(k)];
      end else begin
        w_word[8*k +: 8] = r_mem[r_addr + ADDR_W'(k)];
      end
    end
  end

  // NOTE: every state register uses <= so all of them update from the values
  // seen before the edge, which is what makes a same-edge preload return the old byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_readdata   <= '0;
      r_error      <= 1'b0;
      r_read_count <= '0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.read) begin
            if (w_aligned) begin
              r_addr  <= bus.address;
              r_cnt   <= CNT_LOAD;
              r_state <= S_WAIT;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (!bus.read) begin
            r_state <= S_IDLE;
          end else if (bus.address != r_addr) begin
            // A redirect to a misaligned word is rejected like a fresh bad request.
            if (w_aligned) begin
              r_addr <= bus.address;
              r_cnt  <= CNT_LOAD;
            end else begin
              r_state <= S_IDLE;
              r_error <= 1'b1;
            end
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_readdata <= w_word;
            if (r_read_count != 16'hFFFF) begin
              r_read_count <= r_read_count + 16'd1;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Combinational so the requester stalls in the very cycle it raises READ.
  assign bus.busywait = rst_n &&
                        (((r_state == S_IDLE) && bus.read && w_aligned) ||
                         (r_state == S_WAIT));
  assign bus.readdata = r_readdata;
  assign bus.error    = r_error;
  assign o_read_count = r_read_count;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: a big-endian and a little-endian instance
// share one stimulus stream; expected words come from a byte model via a queue.
module tb_instr_mem_ctrl;

  localparam int ADDR_W = 10;
  localparam int WB     = 4;
  localparam int LAT    = 3;

  typedef struct {
    logic [31:0] be;
    logic [31:0] le;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic [15:0]       rc_be;
  logic [15:0]       rc_le;

  logic [7:0]        model_mem [1 << ADDR_W];
  exp_t              sb_q [$];
  int                exp_cnt = 0;
  int                n_tests = 0;
  int                n_fail  = 0;

  always #5 clk = ~clk;

  instr_mem_ctrl_if #(.ADDR_W(ADDR_W), .WORD_BYTES(WB)) bus ();
  instr_mem_ctrl_if #(.ADDR_W(ADDR_W), .WORD_BYTES(WB)) bus_le ();

  assign bus_le.read    = bus.read;
  assign bus_le.address = bus.address;

  instr_mem_ctrl #(.ADDR_W(ADDR_W), .WORD_BYTES(WB), .LATENCY(LAT), .BIG_ENDIAN(1)) dut_be (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .i_load_en    (load_en),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data),
    .o_read_count (rc_be)
  );

  instr_mem_ctrl #(.ADDR_W(ADDR_W), .WORD_BYTES(WB), .LATENCY(LAT), .BIG_ENDIAN(0)) dut_le (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_le),
    .i_load_en    (load_en),
    .i_load_addr  (load_addr),
    .i_load_data  (load_data),
    .o_read_count (rc_le)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a);
    exp_t e;
    for (int k = 0; k < WB; k++) begin
      e.be[8*(WB-1-k) +: 8] = model_mem[a + ADDR_W'(k)];
      e.le[8*k +: 8]        = model_mem[a + ADDR_W'(k)];
    end
    sb_q.push_back(e);
  endtask

  // Called one step after the edge that should have completed a fetch.
  task automatic complete(input string tag);
    exp_t e;
    check({tag, "_busy_done"}, 64'(bus.busywait), 64'd0);
    check({tag, "_sb_depth"}, 64'(sb_q.size()), 64'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_data_be"}, 64'(bus.readdata), 64'(e.be));
      check({tag, "_data_le"}, 64'(bus_le.readdata), 64'(e.le));
    end
    exp_cnt++;
    check({tag, "_count_be"}, 64'(rc_be), 64'(exp_cnt));
    check({tag, "_count_le"}, 64'(rc_le), 64'(exp_cnt));
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a, input string tag);
    int busy = 0;
    push_exp(a);
    bus.read    = 1'b1;
    bus.address = a;
    #1;
    check({tag, "_busy_req"}, 64'(bus.busywait), 64'd1);
    tick();
    while (bus.busywait && busy < 40) begin
      busy++;
      tick();
    end
    check({tag, "_busy_cycles"}, 64'(busy), 64'(LAT));
    complete(tag);
    bus.read = 1'b0;
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    load_en     = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    bus.read    = 1'b1;
    bus.address = '0;
    #13;
    check("rst_busy_be", 64'(bus.busywait), 64'd0);
    check("rst_busy_le", 64'(bus_le.busywait), 64'd0);
    check("rst_data", 64'(bus.readdata), 64'd0);
    check("rst_error", 64'(bus.error), 64'd0);
    check("rst_count", 64'(rc_be), 64'd0);
    bus.read = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      load_byte(ADDR_W'(i), (i < 4) ? 8'(i + 1) : 8'(8'h11 + i - 4));
    end

    // Basic fetch of word 0 in both byte orders.
    fetch(10'd0, "f0");

    // Misaligned request is rejected with a one-cycle error.
    bus.read    = 1'b1;
    bus.address = 10'd2;
    #1;
    check("mis_busy_req", 64'(bus.busywait), 64'd0);
    tick();
    check("mis_error_hi", 64'(bus.error), 64'd1);
    check("mis_busy_after", 64'(bus.busywait), 64'd0);
    bus.read = 1'b0;
    tick();
    check("mis_error_lo", 64'(bus.error), 64'd0);
    check("mis_count", 64'(rc_be), 64'(exp_cnt));

    // Address change one edge into the wait restarts the latency.
    push_exp(10'd4);
    bus.read    = 1'b1;
    bus.address = 10'd0;
    tick();
    bus.address = 10'd4;
    tick();
    check("relatch_busy", 64'(bus.busywait), 64'd1);
    tick();
    tick();
    check("relatch_busy_late", 64'(bus.busywait), 64'd1);
    check("relatch_data_hold", 64'(bus.readdata), 64'h01020304);
    tick();
    complete("relatch");
    bus.read = 1'b0;
    tick();

    // Dropping READ mid-wait aborts without touching data or count.
    bus.read    = 1'b1;
    bus.address = 10'd0;
    tick();
    tick();
    bus.read = 1'b0;
    tick();
    check("abort_busy", 64'(bus.busywait), 64'd0);
    check("abort_data", 64'(bus.readdata), 64'h11121314);
    check("abort_count", 64'(rc_be), 64'(exp_cnt));
    tick();
    tick();
    check("abort_data_later", 64'(bus.readdata), 64'h11121314);

    // Reset during a wait clears outputs at once; storage survives.
    bus.read    = 1'b1;
    bus.address = 10'd0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busywait), 64'd0);
    check("midrst_data", 64'(bus.readdata), 64'd0);
    check("midrst_count", 64'(rc_be), 64'd0);
    exp_cnt  = 0;
    bus.read = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    fetch(10'd0, "postrst");

    // Preload on the completion edge returns the old byte, new byte next time.
    push_exp(10'd0);
    bus.read    = 1'b1;
    bus.address = 10'd0;
    tick();
    tick();
    tick();
    load_en   = 1'b1;
    load_addr = 10'd0;
    load_data = 8'hAA;
    tick();
    load_en      = 1'b0;
    model_mem[0] = 8'hAA;
    complete("collide");
    bus.read = 1'b0;
    tick();
    fetch(10'd0, "after_collide");
    check("collide_new_word", 64'(bus.readdata), 64'hAA020304);

    // Last word of storage.
    for (int i = 0; i < 4; i++) begin
      load_byte(ADDR_W'(1020 + i), 8'(8'hC0 + i));
    end
    fetch(10'd1020, "top");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width; storage depth SHALL be 2**ADDR_W bytes.
REQ-002 Parameter WORD_BYTES, default 4, bytes per fetched word; power of two, 1..8.
REQ-003 Parameter LATENCY, default 3, wait cycles per fetch; legal range 1..15.
REQ-004 Parameter BIG_ENDIAN, default 1; 1 = byte at ADDRESS is READDATA MSB, 0 = byte at ADDRESS is LSB.
REQ-005 CLK  input  1  single clock; all state changes on posedge.
REQ-006 RESET  input  1  asynchronous, active-low reset.
REQ-007 READ  input  1  fetch request, level, held by requester until BUSYWAIT low.
REQ-008 ADDRESS  input  ADDR_W  byte address of word to fetch.
REQ-009 READDATA  output  8*WORD_BYTES  fetched word, registered.
REQ-010 BUSYWAIT  output  1  fetch in progress; requester stalls while high.
REQ-011 ERROR  output  1  one-cycle pulse, misaligned request rejected.
REQ-012 LOAD_EN  input  1  byte write enable for preloading storage.
REQ-013 LOAD_ADDR  input  ADDR_W  byte address for preload write.
REQ-014 LOAD_DATA  input  8  preload byte.
REQ-015 READ_COUNT  output  16  completed fetches, saturating at 16'hFFFF.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, DONE; the wait counter SHALL be $clog2(LATENCY+1) bits wide.
REQ-017 BUSYWAIT SHALL be combinational: high when (IDLE and READ and ADDRESS aligned) or state is WAIT; low in DONE and while RESET is low.
REQ-018 IDLE, READ high, aligned: at posedge, latch ADDRESS, load counter with LATENCY-1, go to WAIT.
REQ-019 WAIT, counter nonzero: decrement at each posedge.
REQ-020 WAIT, counter zero: at posedge, load READDATA from the latched address per BIG_ENDIAN, increment READ_COUNT, go to DONE; READDATA is therefore valid LATENCY posedges after the request edge.
REQ-021 DONE SHALL last exactly one cycle with BUSYWAIT low and READ ignored, then go to IDLE.
REQ-022 WAIT, ADDRESS differs from the latched address while READ is high: relatch, reload counter with LATENCY-1, stay in WAIT, and leave READDATA and READ_COUNT unchanged.
REQ-023 WAIT, READ low: abort to IDLE at next posedge; READDATA and READ_COUNT unchanged.
REQ-024 IDLE, READ high, ADDRESS mod WORD_BYTES nonzero: no fetch, BUSYWAIT low, ERROR high for the following cycle, state stays IDLE.
REQ-025 LOAD_EN high: write LOAD_DATA to storage[LOAD_ADDR] at posedge, in any state.
REQ-026 A preload to a byte on the same edge READDATA captures it SHALL yield the old byte in READDATA.
REQ-027 Word byte addresses SHALL never wrap, since aligned words lie wholly inside storage.

Reset
REQ-028 RESET low SHALL immediately force state IDLE, counter 0, READDATA 0, ERROR 0, READ_COUNT 0, BUSYWAIT 0, without waiting for CLK.
REQ-029 Reset mid-fetch SHALL discard the fetch; storage contents SHALL NOT be cleared by reset.
REQ-030 After RESET rises, the first request SHALL be sampled at the next posedge.

Verification (defaults, LATENCY=3)
REQ-031 Preload bytes 0..3 = 8'h01,8'h02,8'h03,8'h04; READ=1, ADDRESS=0 -> BUSYWAIT high 3 posedges, READDATA=32'h01020304, READ_COUNT=1, DONE one cycle.
REQ-032 Same stimulus with BIG_ENDIAN=0 -> READDATA=32'h04030201.
REQ-033 READ=1, ADDRESS=2 -> BUSYWAIT never high, ERROR high exactly one cycle, READ_COUNT unchanged.
REQ-034 ADDRESS 0 -> 4 one edge after request -> completion 3 posedges after the change, READDATA=word at 4, READ_COUNT=1.
REQ-035 RESET low in WAIT -> BUSYWAIT=0 and READDATA=0 immediately; after release, fetch of 0 returns 32'h01020304.
REQ-036 Preload byte 0 = 8'hAA on the completion edge of a fetch of 0 -> READDATA=32'h01020304; next fetch of 0 returns 32'hAA020304.
